dff_pipeline: RTL and testbench
===============================

# dff_pipeline

Parametrised multi-stage D flip-flop delay line: a WIDTH-bit data word and a per-stage valid bit are shifted through DEPTH rising-edge registers. It adds a global clock enable (stall), a synchronous flush and a programmable reset value to the single-bit D flip-flop. It sits between producer and consumer logic wherever a fixed, stallable register delay with valid tracking is needed.

## Interface
Parameters:
- WIDTH, 8, data word width in bits, ≥1
- DEPTH, 3, number of register stages (latency), ≥1
- RESET_VALUE, 0, WIDTH-bit value loaded into every data stage on reset and on flush

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  shift enable; 0 = all stages hold
- flush  input  1  synchronous clear of all stages
- d  input  WIDTH  data into stage 0
- d_valid  input  1  valid qualifier for d
- q  output  WIDTH  data out of stage DEPTH-1
- q_valid  output  1  valid qualifier for q
- occupancy  output  $clog2(DEPTH+1)  number of valid stages (present only with DPP_OCCUPANCY_EN)

## Operation
- State: data[0..DEPTH-1] (WIDTH bits each), valid[0..DEPTH-1].
- Priority at each rising edge of clk: reset > flush > en > hold.
- reset=1: every data[i] ← RESET_VALUE, every valid[i] ← 0, occupancy ← 0.
- flush=1 (reset=0): same effect as reset, regardless of en; the input word presented on that edge is discarded.
- en=1 (reset=0, flush=0): data[0] ← d, valid[0] ← d_valid; data[i] ← data[i-1], valid[i] ← valid[i-1] for i=1..DEPTH-1; the word in stage DEPTH-1 is dropped.
- en=0: all stages hold; d/d_valid ignored.
- Data shifts regardless of valid; an invalid word still propagates, and its data is don't-care to consumers.
- q = data[DEPTH-1], q_valid = valid[DEPTH-1], both driven directly from registers. No combinational path from any input to any output.
- DEPTH=1 degenerates to a single enable/flush/reset register.

## Timing
- Reset values: q = RESET_VALUE, q_valid = 0, occupancy = 0, all visible in the cycle after the reset edge.
- Latency: a word sampled on the k-th enabled edge appears on q after the (k+DEPTH-1)-th enabled edge, i.e. exactly DEPTH enabled edges from d to q. Disabled cycles add no stage movement.
- Throughput: one word per enabled cycle.
- reset or flush asserted while en=1 and d_valid=1: the word is lost and outputs read reset values next cycle.
- reset/flush deasserted: the first enabled edge afterwards loads stage 0 normally.
- occupancy is registered and equals the popcount of valid[] after every edge. An enabled edge changes it by +1 (valid in, invalid out), −1 (invalid in, valid out) or 0. It never exceeds DEPTH and never underflows.

## Configuration
- DPP_OCCUPANCY_EN defined: occupancy port and its $clog2(DEPTH+1)-bit registered counter are compiled in, with behaviour as above.
- Not defined: occupancy port and counter are absent. All other behaviour and timing are identical.

## Test plan
(All scenarios use WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5.)
- Reset: hold reset=1 for 2 cycles with d=8'hFF, d_valid=1, en=1 -> q=8'hA5, q_valid=0, occupancy=0 after each edge.
- Latency and streaming: en=1, inject 8'h01, 8'h02, 8'h03 valid on consecutive edges, then d_valid=0 -> q=8'h01/q_valid=1 after the 3rd edge, then 8'h02 and 8'h03 on the next edges, then q_valid=0. occupancy sequence 1,2,3,2,1,0.
- Stall: inject 8'h10 valid, drop en for 4 cycles, then re-enable -> q and q_valid frozen during the stall, 8'h10 appears after 2 more enabled edges, occupancy constant during the stall.
- Flush mid-stream: pipeline holding 8'h21, 8'h22, 8'h23 valid, assert flush with en=1, d=8'h24 valid -> next cycle q=8'hA5, q_valid=0, occupancy=0, and 8'h24 never emerges.
- Priority: assert reset and flush together with en=0 -> reset values. Assert flush with en=0 on a full pipeline -> cleared despite en=0.
- Bubbles: alternate d_valid 1/0 with data 8'h31, 8'h32, 8'h33, 8'h34 -> q_valid pattern 1,0,1,0 delayed by 3 edges, and occupancy never exceeds 2.

Source files
------------

// File: rtl/dff_pipeline_if.sv
// Bus bundle for dff_pipeline: producer-side controls/data in, delayed data out.
// The occupancy member exists only when DPP_OCCUPANCY_EN is defined.
interface dff_pipeline_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [WIDTH-1:0] q;
  logic             q_valid;
`ifdef DPP_OCCUPANCY_EN
  logic [OCC_W-1:0] occupancy;
`endif

  modport master (
    output en, flush, d, d_valid,
`ifdef DPP_OCCUPANCY_EN
    input  occupancy,
`endif
    input  q, q_valid
  );

  modport slave (
    input  en, flush, d, d_valid,
`ifdef DPP_OCCUPANCY_EN
    output occupancy,
`endif
    output q, q_valid
  );
endinterface

// File: rtl/dff_pipeline.sv
// Stallable, flushable DEPTH-stage register delay line with per-stage valid.
// Optional registered occupancy counter enabled by defining DPP_OCCUPANCY_EN.
module dff_pipeline #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic           clk,
  input  logic           reset,
  dff_pipeline_if.slave  bus
);
  logic [DEPTH-1:0][WIDTH-1:0] r_data;
  logic [DEPTH-1:0]            r_vld;
  logic                        w_clr;

  assign w_clr = reset | bus.flush;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_data <= {DEPTH{RESET_VALUE}};
      r_vld  <= '0;
    end else if (bus.en) begin
      r_data[0] <= bus.d;
      r_vld[0]  <= bus.d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i] <= r_data[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
    end
  end

  assign bus.q       = r_data[DEPTH-1];
  assign bus.q_valid = r_vld[DEPTH-1];

`ifdef DPP_OCCUPANCY_EN
  localparam int OCC_W = $clog2(DEPTH + 1);
  logic [OCC_W-1:0] r_occ;

  // Tracked incrementally: one word enters and one leaves per enabled edge.
  always_ff @(posedge clk) begin
    if (w_clr)
      r_occ <= '0;
    else if (bus.en)
      r_occ <= r_occ + OCC_W'(bus.d_valid) - OCC_W'(r_vld[DEPTH-1]);
  end

  assign bus.occupancy = r_occ;
`endif
endmodule

// File: tb/tb_dff_pipeline.sv
// Randomised + directed bench for dff_pipeline against a queue-based delay-line model.
module tb_dff_pipeline;
  localparam int         WIDTH = 8;
  localparam int         DEPTH = 3;
  localparam logic [7:0] RV    = 8'hA5;

  logic clk = 0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  bit   model_ok = 0;
  int   occ_max;

  dff_pipeline_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  dff_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: a FIFO of exactly DEPTH {valid,data} entries, front = newest.
  logic [8:0] mq [$];

  function automatic int model_occ();
    int n = 0;
    foreach (mq[i]) n += int'(mq[i][8]);
    return n;
  endfunction

  always @(posedge clk) begin
    if (reset || bus.flush) begin
      mq.delete();
      for (int i = 0; i < DEPTH; i++) mq.push_back({1'b0, RV});
      model_ok = 1;
    end else if (bus.en && model_ok) begin
      mq.push_front({bus.d_valid, bus.d});
      void'(mq.pop_back());
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_q", int'(bus.q), int'(mq[DEPTH-1][7:0]));
      chk("model_q_valid", int'(bus.q_valid), int'(mq[DEPTH-1][8]));
`ifdef DPP_OCCUPANCY_EN
      chk("model_occ", int'(bus.occupancy), model_occ());
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string name, input logic [7:0] eq, input logic ev, input int eocc);
    chk({name, "_q"}, int'(bus.q), int'(eq));
    chk({name, "_qv"}, int'(bus.q_valid), int'(ev));
`ifdef DPP_OCCUPANCY_EN
    chk({name, "_occ"}, int'(bus.occupancy), eocc);
`endif
  endtask

  task automatic expect_v(input string name, input logic ev, input int eocc);
    chk({name, "_qv"}, int'(bus.q_valid), int'(ev));
`ifdef DPP_OCCUPANCY_EN
    chk({name, "_occ"}, int'(bus.occupancy), eocc);
`endif
  endtask

  task automatic drive(input logic e, input logic f, input logic [7:0] dd, input logic dv);
    bus.en = e; bus.flush = f; bus.d = dd; bus.d_valid = dv;
  endtask

  initial begin
    reset = 1;
    drive(1, 0, 8'hFF, 1);
    // Reset held two cycles with a valid word presented
    step(); expect_out("rst1", RV, 0, 0);
    step(); expect_out("rst2", RV, 0, 0);
    reset = 0;

    // Latency and streaming
    drive(1, 0, 8'h01, 1); step(); expect_v("str1", 0, 1);
    drive(1, 0, 8'h02, 1); step(); expect_v("str2", 0, 2);
    drive(1, 0, 8'h03, 1); step(); expect_out("str3", 8'h01, 1, 3);
    drive(1, 0, 8'h00, 0); step(); expect_out("str4", 8'h02, 1, 2);
    step(); expect_out("str5", 8'h03, 1, 1);
    step(); expect_v("str6", 0, 0);

    // Stall
    drive(1, 0, 8'h10, 1); step(); expect_v("stl0", 0, 1);
    drive(0, 0, 8'h77, 1);
    for (int i = 0; i < 4; i++) begin step(); expect_v("stall", 0, 1); end
    drive(1, 0, 8'h00, 0); step(); expect_v("stl5", 0, 1);
    step(); expect_out("stl6", 8'h10, 1, 1);
    step(); expect_v("stl7", 0, 0);

    // Flush mid-stream with a valid word presented
    drive(1, 0, 8'h21, 1); step();
    drive(1, 0, 8'h22, 1); step();
    drive(1, 0, 8'h23, 1); step(); expect_out("fl_pre", 8'h21, 1, 3);
    drive(1, 1, 8'h24, 1); step(); expect_out("fl", RV, 0, 0);
    drive(1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin step(); expect_v("fl_post", 0, 0); end

    // Priority: reset+flush with en=0, then flush alone with en=0
    for (int i = 0; i < 3; i++) begin drive(1, 0, 8'(8'h41 + i), 1); step(); end
    reset = 1; drive(0, 1, 8'h00, 0); step(); expect_out("pri_rf", RV, 0, 0);
    reset = 0;
    for (int i = 0; i < 3; i++) begin drive(1, 0, 8'(8'h51 + i), 1); step(); end
    expect_out("pri_full", 8'h51, 1, 3);
    drive(0, 1, 8'h00, 0); step(); expect_out("pri_f", RV, 0, 0);

    // Bubbles
    occ_max = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 8'(8'h31 + i), (i < 4) ? ((i % 2) == 0) : 1'b0);
      step();
`ifdef DPP_OCCUPANCY_EN
      if (int'(bus.occupancy) > occ_max) occ_max = int'(bus.occupancy);
`endif
      if (i == 2) expect_out("bub3", 8'h31, 1, 2);
      if (i == 3) chk("bub4_qv", int'(bus.q_valid), 0);
      if (i == 4) expect_out("bub5", 8'h33, 1, 1);
      if (i == 5) chk("bub6_qv", int'(bus.q_valid), 0);
    end
`ifdef DPP_OCCUPANCY_EN
    chk("bub_occ_max", occ_max, 2);
`endif

    // Randomised traffic, checked every cycle by the model comparator
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0),
            8'($urandom), 1'($urandom));
      step();
    end
    reset = 0; drive(0, 0, 8'h00, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
